// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_unit
// Description : Iterative multi-cycle multiply/divide unit that owns the
//               architectural HI/LO registers. It implements MULT, MULTU,
//               DIV, DIVU (one iteration per clock, WIDTH iterations plus a
//               final sign-fix cycle) and MTHI/MTLO writes. HI/LO are always
//               readable, which covers MFHI/MFLO.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous active-high reset, clears all state
//   start        in   1      issue op; accepted only when busy=0
//   op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op_a         in   WIDTH  multiplicand / dividend (rs)
//   op_b         in   WIDTH  multiplier / divisor (rt)
//   mthi         in   1      write wr_data to HI (idle only)
//   mtlo         in   1      write wr_data to LO (idle only)
//   wr_data      in   WIDTH  MTHI/MTLO data
//   busy         out  1      op in flight
//   done         out  1      one-cycle pulse when HI/LO take a result
//   div_by_zero  out  1      set with done for a divide by zero, cleared on
//                            the next accepted start
//   hi           out  WIDTH  HI register
//   lo           out  WIDTH  LO register
// ============================================================================
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;       // iterations remaining in RUN
    logic               r_is_div;
    logic               r_neg_q;     // negate product / quotient in FIX
    logic               r_neg_r;     // negate remainder in FIX
    logic               r_b_zero;    // divide by zero detected at issue
    logic [WIDTH-1:0]   r_a_orig;    // raw dividend, HI result for div by zero
    logic [WIDTH-1:0]   r_mcand;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_wh;        // working upper half / partial remainder
    logic [WIDTH-1:0]   r_wl;        // working lower half / quotient bits
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    // ------------------------------------------------------------------------
    // Operand magnitudes. The magnitude is kept as an unsigned WIDTH-bit
    // value, so two's-complement negation of MIN_INT yields exactly
    // 2^(WIDTH-1) without any extra bit.
    // ------------------------------------------------------------------------
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & op_a[WIDTH-1];
    assign w_b_neg  = w_signed & op_b[WIDTH-1];
    assign w_mag_a  = w_a_neg ? (~op_a + 1'b1) : op_a;
    assign w_mag_b  = w_b_neg ? (~op_b + 1'b1) : op_b;

    // ------------------------------------------------------------------------
    // One iteration of the datapath.
    // Multiply: shift-add. {r_wh,r_wl} holds {partial product, multiplier};
    //   the low multiplier bit selects whether the multiplicand is added to
    //   the upper half, then the whole pair shifts right by one.
    // Divide: restoring. {r_wh,r_wl} holds {partial remainder, dividend};
    //   shift left one, trial-subtract the divisor and shift the resulting
    //   quotient bit into the bottom of r_wl.
    // ------------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;

    always_comb begin
        w_mul_sum = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_shift   = {r_wh, r_wl[WIDTH-1]};
        w_ge      = (w_shift >= {1'b0, r_mcand});
        // When w_ge holds the difference is below the divisor, so it always
        // fits in WIDTH bits and the modulo subtraction is exact.
        w_diff    = w_shift[WIDTH-1:0] - r_mcand;
        if (r_is_div) begin
            w_step_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
            w_step_lo = {r_wl[WIDTH-2:0], w_ge};
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_wl[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------------
    // Final sign correction and divide-by-zero substitution.
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_prod     = {r_wh, r_wl};
    assign w_prod_neg = ~w_prod + 1'b1;

    always_comb begin
        w_fix_hi = r_wh;
        w_fix_lo = r_wl;
        if (!r_is_div) begin
            w_fix_hi = r_neg_q ? w_prod_neg[2*WIDTH-1:WIDTH] : w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = r_neg_q ? w_prod_neg[WIDTH-1:0]       : w_prod[WIDTH-1:0];
        end else if (r_b_zero) begin
            w_fix_hi = r_a_orig;
            w_fix_lo = {WIDTH{1'b1}};
        end else begin
            // Truncating division: quotient carries sign(a)^sign(b),
            // remainder carries sign(a). MIN_INT/-1 falls out naturally as
            // the negation of 2^(WIDTH-1), which is MIN_INT again.
            w_fix_hi = r_neg_r ? (~r_wh + 1'b1) : r_wh;
            w_fix_lo = r_neg_q ? (~r_wl + 1'b1) : r_wl;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and all state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_a_orig <= '0;
            r_mcand  <= '0;
            r_wh     <= '0;
            r_wl     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Accepting an op drops any coincident MT* write.
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_dbz    <= 1'b0;
                        r_cnt    <= c_CNT_W'(WIDTH);
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_b_zero <= op[1] & (op_b == '0);
                        r_a_orig <= op_a;
                        r_wh     <= '0;
                        r_wl     <= op[1] ? w_mag_a : w_mag_b;
                        r_mcand  <= op[1] ? w_mag_b : w_mag_a;
                    end else begin
                        if (mthi) begin
                            r_hi <= wr_data;
                        end
                        if (mtlo) begin
                            r_lo <= wr_data;
                        end
                    end
                end
                S_RUN: begin
                    r_wh  <= w_step_hi;
                    r_wl  <= w_step_lo;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_dbz   <= r_b_zero;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_muldiv_unit
// Description : Self-checking bench for hilo_muldiv_unit (WIDTH=32). A
//               cycle-level reference model computes results with plain
//               64-bit arithmetic and a latency countdown; a compare process
//               checks every output each cycle, and directed vectors pin
//               hand-computed results, latency and corner cases.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .op_a        (op_a),
        .op_b        (op_b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic void model_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] h, output logic [W-1:0] l, output bit z);
        logic [2*W-1:0] p;
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z = 1'b0;
        h = '0;
        l = '0;
        case (o)
            2'b00: begin p = sa * sb;                   h = p[2*W-1:W]; l = p[W-1:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b};   h = p[2*W-1:W]; l = p[W-1:0]; end
            default: begin
                if (b == '0) begin
                    h = a; l = '1; z = 1'b1;
                end else if (o == 2'b10) begin
                    l = W'(sa / sb);
                    h = W'(sa % sb);
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit           m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
    int           m_left = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = W + 1;
                m_dbz  = 1'b0;
                model_op(op, op_a, op_b, p_hi, p_lo, p_dbz);
            end else begin
                if (mthi) m_hi = wr_data;
                if (mtlo) m_lo = wr_data;
            end
        end
    end

    // Every-cycle comparison, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        chk("cyc busy", busy, m_busy);
        chk("cyc done", done, m_done);
        chk("cyc div_by_zero", div_by_zero, m_dbz);
        chk("cyc hi", hi, m_hi);
        chk("cyc lo", lo, m_lo);
    end

    // ------------------------------------------------------------------------
    // Directed stimulus (inputs change on the falling edge)
    // ------------------------------------------------------------------------
    // Presents an op for one edge, then scrambles the operand inputs to show
    // they were latched at acceptance. Returns one falling edge after accept.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = ~o; op_a = $urandom; op_b = $urandom;
    endtask

    // k counts falling edges since the start was presented; done rises on
    // edge E33 after acceptance at E0, i.e. seen at the 34th falling edge.
    task automatic wait_done(input string name, input int k0, input logic [W-1:0] eh,
                             input logic [W-1:0] el, input bit ez);
        int k = k0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({name, " done"}, done, 1'b1);
        chk({name, " latency"}, k, 34);
        chk({name, " busy"}, busy, 1'b0);
        chk({name, " hi"}, hi, eh);
        chk({name, " lo"}, lo, el);
        chk({name, " div_by_zero"}, div_by_zero, ez);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset dbz", div_by_zero, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // MTHI alone, then MTHI+MTLO together
        mthi = 1'b1; wr_data = 32'h11;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi hi", hi, 32'h11);
        chk("mthi lo", lo, 32'h0);
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h22;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthi+mtlo hi", hi, 32'h22);
        chk("mthi+mtlo lo", lo, 32'h22);

        // MULT -3*5 with a coincident MTHI that must be dropped
        mthi = 1'b1; wr_data = 32'h5555;
        issue(2'b00, 32'hFFFFFFFD, 32'd5);
        chk("start-wins hi", hi, 32'h22);
        chk("start busy", busy, 1'b1);
        wait_done("MULT -3*5", 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);

        // Back-to-back issues in the done cycle
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("MULTU max*max", 1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        issue(2'b00, 32'h80000000, 32'h80000000);
        wait_done("MULT min*min", 1, 32'h40000000, 32'h0, 1'b0);
        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_done("DIV -7/2", 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        issue(2'b11, 32'd7, 32'd2);
        wait_done("DIVU 7/2", 1, 32'h1, 32'h3, 1'b0);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done("DIV min/-1", 1, 32'h0, 32'h80000000, 1'b0);
        issue(2'b11, 32'h1234, 32'h0);
        wait_done("DIVU by zero", 1, 32'h1234, 32'hFFFFFFFF, 1'b1);
        repeat (2) @(negedge clk);
        chk("dbz sticky", div_by_zero, 1'b1);

        // DIVU 100/7 with a stray start and MTLO while busy
        issue(2'b11, 32'd100, 32'd7);
        chk("dbz cleared", div_by_zero, 1'b0);
        repeat (4) @(negedge clk);
        op = 2'b00; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        mtlo = 1'b1; wr_data = 32'hAA;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        chk("busy mtlo ignored", lo, 32'hFFFFFFFF);
        wait_done("DIVU 100/7", 6, 32'd2, 32'd14, 1'b0);

        // Reset mid-run, then a normal signed divide
        @(negedge clk);
        issue(2'b00, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async rst busy", busy, 1'b0);
        chk("async rst done", done, 1'b0);
        chk("async rst hi", hi, 32'h0);
        chk("async rst lo", lo, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(2'b10, 32'hFFFFFF9C, 32'd7);
        wait_done("DIV -100/7", 1, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
